capp_array_controller: RTL

- Sequencer that drives one CAPP cell array.
- Takes SEARCH/WRITE/READ commands over a valid/ready handshake and encodes each one onto the array's 64-bit match and write line pairs.
- Holds those lines for a fixed settle window, then samples the array's tag (mismatch) lines or read lines.
- Returns the result (responder count, first responder, read data) over a valid/ready response port.

---
 rtl/capp_array_controller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/capp_array_controller.sv
// capp_array_controller: sequences SEARCH/WRITE/READ commands onto one CAPP cell array.
// A command is latched in IDLE. The match/write line pairs are held for SETTLE_CYCLES
// in DRIVE, then the tag or read lines are sampled. The result is offered in RESP.
// Optional build macro CAPP_CTRL_COUNT_EN adds a registered responder popcount.
// This costs SEARCH one extra cycle. Without the macro, rsp_count is tied to 0.
module capp_array_controller #(
    parameter int unsigned WORDS         = 100,
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned IDXW          = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic [WIDTH-1:0]   cmd_mask,
    output logic [2*WIDTH-1:0] match_lines,
    output logic [2*WIDTH-1:0] write_lines,
    input  logic [WORDS-1:0]   mismatch_lines,
    input  logic [WIDTH-1:0]   read_lines,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [IDXW-1:0]    rsp_count,
    output logic [IDXW-1:0]    rsp_first,
    output logic               rsp_some,
    output logic               rsp_err
);

    localparam logic [1:0] OpSearch = 2'b00;
    localparam logic [1:0] OpWrite  = 2'b01;
    localparam logic [1:0] OpRead   = 2'b10;
    localparam logic [1:0] OpRsvd   = 2'b11;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    // StCount is only reachable when the popcount stage is built in.
    typedef enum logic [1:0] {StIdle, StDrive, StCount, StResp} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [IDXW-1:0]    rsp_first_q, rsp_first_d;
    logic               rsp_some_q, rsp_some_d;
    logic               rsp_err_q, rsp_err_d;
    logic [IDXW-1:0]    first_c;
    logic               some_c;
`ifdef CAPP_CTRL_COUNT_EN
    logic [WORDS-1:0]   tags_q, tags_d;
    logic [IDXW-1:0]    rsp_count_q, rsp_count_d;
    logic [IDXW-1:0]    pop_c;
`endif

    // Priority encode the lowest responder (tag 0) straight off the array.
    always_comb begin
        first_c = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (!mismatch_lines[i]) begin
                first_c = IDXW'(i);
            end
        end
        some_c = ~&mismatch_lines;
    end

`ifdef CAPP_CTRL_COUNT_EN
    // Popcount of responders, taken from the tags captured on the last DRIVE cycle.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < WORDS; i++) begin
            pop_c = pop_c + IDXW'(~tags_q[i]);
        end
    end
`endif

    // Next-state, settle counter and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        data_d      = data_q;
        mask_d      = mask_q;
        rsp_data_d  = rsp_data_q;
        rsp_first_d = rsp_first_q;
        rsp_some_d  = rsp_some_q;
        rsp_err_d   = rsp_err_q;
`ifdef CAPP_CTRL_COUNT_EN
        tags_d      = tags_q;
        rsp_count_d = rsp_count_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    data_d      = cmd_data;
                    mask_d      = cmd_mask;
                    cnt_d       = SettleLoad;
                    // Clear every field, so that each op only fills in its own fields.
                    rsp_data_d  = '0;
                    rsp_first_d = '0;
                    rsp_some_d  = 1'b0;
                    rsp_err_d   = (cmd_op == OpRsvd);
`ifdef CAPP_CTRL_COUNT_EN
                    rsp_count_d = '0;
`endif
                    state_d     = (cmd_op == OpRsvd) ? StResp : StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    if (op_q == OpSearch) begin
                        rsp_first_d = first_c;
                        rsp_some_d  = some_c;
`ifdef CAPP_CTRL_COUNT_EN
                        tags_d      = mismatch_lines;
                        state_d     = StCount;
`endif
                    end else if (op_q == OpRead) begin
                        rsp_data_d = read_lines;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCount: begin
`ifdef CAPP_CTRL_COUNT_EN
                rsp_count_d = pop_c;
`endif
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line encoding. Lines are driven only in DRIVE, so an async reset drops them at once.
    always_comb begin
        match_lines = '0;
        write_lines = '0;
        if (state_q == StDrive) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (mask_q[j]) begin
                    if (op_q == OpSearch) begin
                        match_lines[2*j + (data_q[j] ? 1 : 0)] = 1'b1;
                    end else if (op_q == OpWrite) begin
                        write_lines[2*j + (data_q[j] ? 0 : 1)] = 1'b1;
                    end
                end
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            rsp_data_q  <= '0;
            rsp_first_q <= '0;
            rsp_some_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef CAPP_CTRL_COUNT_EN
            tags_q      <= '1;
            rsp_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            rsp_data_q  <= rsp_data_d;
            rsp_first_q <= rsp_first_d;
            rsp_some_q  <= rsp_some_d;
            rsp_err_q   <= rsp_err_d;
`ifdef CAPP_CTRL_COUNT_EN
            tags_q      <= tags_d;
            rsp_count_q <= rsp_count_d;
`endif
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_first = rsp_first_q;
    assign rsp_some  = rsp_some_q;
    assign rsp_err   = rsp_err_q;
`ifdef CAPP_CTRL_COUNT_EN
    assign rsp_count = rsp_count_q;
`else
    assign rsp_count = '0;
`endif

endmodule
